// File: rtl/seq_det_pkg.sv
// Shared definitions for the sequence-detector controller slice.
//   state_t        : controller FSM states
//   DEF_WIDTH      : default bits per serialized word
//   DEF_CNT_W      : default hit-counter width
//   DEF_IDLE_BIT   : default serial value between words
package seq_det_pkg;

    localparam int   DEF_WIDTH    = 8;
    localparam int   DEF_CNT_W    = 4;
    localparam logic DEF_IDLE_BIT = 1'b0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        DRAIN  = 2'd2,
        RESULT = 2'd3
    } state_t;

endpackage

// File: rtl/det_hit_capture.sv
// Captures Mealy/Moore detector flags into per-bit hit masks and produces
// popcounts plus a disagreement flag.
//   clk, rst          : clock, async active-high reset
//   clr               : clear masks/counts (word accepted)
//   me_en             : sample flag_me into me_mask[idx]
//   mo_en             : sample flag_mo into mo_mask[idx+1]
//   fin               : DRAIN cycle; sample flag_mo into mo_mask[0], update counts
//   idx               : bit index carried by the current serial bit
//   flag_me, flag_mo  : detector flags
//   me_mask, mo_mask  : hit masks
//   me_cnt, mo_cnt    : popcounts of the masks
//   mismatch          : masks differ
module det_hit_capture #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4,
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             me_en,
    input  logic             mo_en,
    input  logic             fin,
    input  logic [IDX_W-1:0] idx,
    input  logic             flag_me,
    input  logic             flag_mo,
    output logic [WIDTH-1:0] me_mask,
    output logic [WIDTH-1:0] mo_mask,
    output logic [CNT_W-1:0] me_cnt,
    output logic [CNT_W-1:0] mo_cnt,
    output logic             mismatch
);

    logic [WIDTH-1:0] me_next;
    logic [WIDTH-1:0] mo_next;
    logic [CNT_W-1:0] me_pop;
    logic [CNT_W-1:0] mo_pop;
    logic [IDX_W-1:0] mo_idx;

    // The Moore flag lags one bit, so it belongs to the previously driven bit.
    assign mo_idx = idx + IDX_W'(1);

    always_comb begin
        me_next = me_mask;
        mo_next = mo_mask;
        if (me_en) me_next[idx] = flag_me;
        if (mo_en) mo_next[mo_idx] = flag_mo;
        if (fin)   mo_next[0] = flag_mo;
    end

    // Counts are taken from the next-state masks so the final DRAIN sample
    // is included on the same edge.
    always_comb begin
        me_pop = '0;
        mo_pop = '0;
        for (int i = 0; i < WIDTH; i++) begin
            me_pop = me_pop + CNT_W'(me_next[i]);
            mo_pop = mo_pop + CNT_W'(mo_next[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            me_mask  <= '0;
            mo_mask  <= '0;
            me_cnt   <= '0;
            mo_cnt   <= '0;
            mismatch <= 1'b0;
        end else if (clr) begin
            me_mask  <= '0;
            mo_mask  <= '0;
            me_cnt   <= '0;
            mo_cnt   <= '0;
            mismatch <= 1'b0;
        end else begin
            me_mask <= me_next;
            mo_mask <= mo_next;
            if (fin) begin
                me_cnt   <= me_pop;
                mo_cnt   <= mo_pop;
                mismatch <= (me_next != mo_next);
            end
        end
    end

endmodule

// File: rtl/seq_det_ctrl.sv
// Sequences the serial Mealy/Moore detector pair: accepts a word, shifts it
// out MSB-first on det_din, captures both flags bit-aligned and returns hit
// masks, counts and a disagreement flag.
//   clk                  : clock
//   rst_n                : async reset, active-high (historical name)
//   in_valid/in_ready    : input word handshake, in_data word
//   det_din              : registered serial bit to both detectors
//   flag_me, flag_mo     : Mealy flag (current bit), Moore flag (previous bit)
//   out_valid/out_ready  : result handshake
//   me_mask, mo_mask     : per-bit hit masks
//   me_cnt, mo_cnt       : hit counts
//   mismatch             : me_mask != mo_mask
//
// state  | meaning
// IDLE   | waiting for a word, in_ready = 1
// SHIFT  | WIDTH cycles, one serial bit per cycle
// DRAIN  | one cycle to collect the lagging Moore flag of bit 0
// RESULT | out_valid = 1, outputs held until accepted
module seq_det_ctrl
    import seq_det_pkg::*;
#(
    parameter int   WIDTH    = DEF_WIDTH,
    parameter int   CNT_W    = DEF_CNT_W,
    parameter logic IDLE_BIT = DEF_IDLE_BIT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             det_din,
    input  logic             flag_me,
    input  logic             flag_mo,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] me_mask,
    output logic [WIDTH-1:0] mo_mask,
    output logic [CNT_W-1:0] me_cnt,
    output logic [CNT_W-1:0] mo_cnt,
    output logic             mismatch
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] sh;
    logic [IDX_W-1:0] idx;
    logic             accept;
    logic             cap_me_en;
    logic             cap_mo_en;
    logic             cap_fin;
    logic             last_bit;
    logic             first_bit;

    assign last_bit  = (idx == '0);
    assign first_bit = (idx == IDX_W'(WIDTH - 1));

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        accept     = 1'b0;
        cap_me_en  = 1'b0;
        cap_mo_en  = 1'b0;
        cap_fin    = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept     = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                cap_me_en = 1'b1;
                // First SHIFT cycle's Moore flag refers to the gap bit, not this word.
                cap_mo_en = !first_bit;
                if (last_bit) state_next = DRAIN;
            end
            DRAIN: begin
                cap_fin    = 1'b1;
                state_next = RESULT;
            end
            RESULT: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // sh holds the bits still to be sent, next bit always at the MSB.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            sh      <= '0;
            idx     <= '0;
            det_din <= IDLE_BIT;
        end else if (accept) begin
            sh      <= in_data << 1;
            idx     <= IDX_W'(WIDTH - 1);
            det_din <= in_data[WIDTH-1];
        end else if (state == SHIFT) begin
            sh <= sh << 1;
            if (last_bit) begin
                det_din <= IDLE_BIT;
            end else begin
                det_din <= sh[WIDTH-1];
                idx     <= idx - IDX_W'(1);
            end
        end else begin
            det_din <= IDLE_BIT;
        end
    end

    det_hit_capture #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W),
        .IDX_W (IDX_W)
    ) u_cap (
        .clk      (clk),
        .rst      (rst_n),
        .clr      (accept),
        .me_en    (cap_me_en),
        .mo_en    (cap_mo_en),
        .fin      (cap_fin),
        .idx      (idx),
        .flag_me  (flag_me),
        .flag_mo  (flag_mo),
        .me_mask  (me_mask),
        .mo_mask  (mo_mask),
        .me_cnt   (me_cnt),
        .mo_cnt   (mo_cnt),
        .mismatch (mismatch)
    );

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Directed bench for seq_det_ctrl: flag stubs driven per SHIFT/DRAIN cycle,
// expected masks/counts hand-computed per word.
module tb_seq_det_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       det_din;
    logic       flag_me;
    logic       flag_mo;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] me_mask;
    logic [7:0] mo_mask;
    logic [3:0] me_cnt;
    logic [3:0] mo_cnt;
    logic       mismatch;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    seq_det_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .det_din   (det_din),
        .flag_me   (flag_me),
        .flag_mo   (flag_mo),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .me_mask   (me_mask),
        .mo_mask   (mo_mask),
        .me_cnt    (me_cnt),
        .mo_cnt    (mo_cnt),
        .mismatch  (mismatch)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // me_cyc/mo_cyc: bit 7 = flag in SHIFT cycle 1 ... bit 0 = SHIFT cycle 8.
    // mo_dr: flag level (both flags) during DRAIN. hold: RESULT cycles with out_ready=0.
    task automatic run_word(input string name, input logic [7:0] data,
                            input logic [7:0] din_seq,
                            input logic [7:0] me_cyc, input logic [7:0] mo_cyc,
                            input logic mo_dr,
                            input logic [7:0] exp_me, input logic [7:0] exp_mo,
                            input logic [3:0] exp_mc, input logic [3:0] exp_oc,
                            input logic exp_mm, input int hold);
        chk({name, ".in_ready_idle"}, in_ready, 1'b1);
        in_valid = 1'b1;
        in_data  = data;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int c = 0; c < 8; c++) begin
            flag_me = me_cyc[7-c];
            flag_mo = mo_cyc[7-c];
            @(negedge clk);
            chk($sformatf("%s.det_din[%0d]", name, c), det_din, din_seq[7-c]);
            if (c == 3) chk({name, ".in_ready_shift"}, in_ready, 1'b0);
            @(posedge clk); #1;
        end
        flag_me = mo_dr;
        flag_mo = mo_dr;
        @(negedge clk);
        chk({name, ".drain_din"}, det_din, 1'b0);
        chk({name, ".drain_ov"}, out_valid, 1'b0);
        out_ready = (hold == 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk({name, ".out_valid"}, out_valid, 1'b1);
        chk({name, ".me_mask"}, me_mask, exp_me);
        chk({name, ".mo_mask"}, mo_mask, exp_mo);
        chk({name, ".me_cnt"}, me_cnt, exp_mc);
        chk({name, ".mo_cnt"}, mo_cnt, exp_oc);
        chk({name, ".mismatch"}, mismatch, exp_mm);
        chk({name, ".in_ready_res"}, in_ready, 1'b0);
        for (int k = 0; k < hold; k++) begin
            in_valid = 1'b1;
            in_data  = ~data;
            @(posedge clk); #1;
            @(negedge clk);
            chk($sformatf("%s.hold_ov[%0d]", name, k), out_valid, 1'b1);
            chk($sformatf("%s.hold_ir[%0d]", name, k), in_ready, 1'b0);
            chk($sformatf("%s.hold_me[%0d]", name, k), me_mask, exp_me);
            chk($sformatf("%s.hold_mo[%0d]", name, k), mo_mask, exp_mo);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk({name, ".ov_after_hs"}, out_valid, 1'b0);
        chk({name, ".ir_after_hs"}, in_ready, 1'b1);
        flag_me = 1'b0;
        flag_mo = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        flag_me   = 1'b0;
        flag_mo   = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.out_valid", out_valid, 1'b0);
        chk("rst.in_ready", in_ready, 1'b1);
        chk("rst.det_din", det_din, 1'b0);
        chk("rst.masks", {me_mask, mo_mask}, 16'h0000);
        rst_n = 1'b0;
        @(negedge clk);

        // Serialization, flags tied low.
        run_word("ser", 8'b1010_1011, 8'b1010_1011, 8'h00, 8'h00, 1'b0,
                 8'h00, 8'h00, 4'd0, 4'd0, 1'b0, 0);
        // Alignment: Mealy in cycle 5, Moore in cycle 6 -> both on bit 3.
        run_word("align", 8'b0110_0101, 8'b0110_0101, 8'b0000_1000, 8'b0000_0100, 1'b0,
                 8'b0000_1000, 8'b0000_1000, 4'd1, 4'd1, 1'b0, 0);
        // Last bit: Mealy in cycle 8, Moore in DRAIN -> bit 0.
        run_word("last", 8'hC3, 8'hC3, 8'b0000_0001, 8'h00, 1'b1,
                 8'h01, 8'h01, 4'd1, 4'd1, 1'b0, 0);
        // DRAIN Moore pulse omitted.
        run_word("nodrain", 8'h5A, 8'h5A, 8'b0000_0001, 8'h00, 1'b0,
                 8'h01, 8'h00, 4'd1, 4'd0, 1'b1, 0);
        // Moore pulse only in cycle 1 belongs to the gap bit -> ignored.
        run_word("mofirst", 8'hFF, 8'hFF, 8'h00, 8'h80, 1'b0,
                 8'h00, 8'h00, 4'd0, 4'd0, 1'b0, 0);
        // Both flags constantly high.
        flag_me = 1'b1;
        flag_mo = 1'b1;
        run_word("allones", 8'h96, 8'h96, 8'hFF, 8'hFF, 1'b1,
                 8'hFF, 8'hFF, 4'd8, 4'd8, 1'b0, 0);
        // Back-pressure: 5 stalled RESULT cycles with in_valid high; the
        // next word is accepted on the edge after in_ready returns.
        run_word("bp", 8'h3C, 8'h3C, 8'b0100_0000, 8'b0010_0000, 1'b0,
                 8'b0100_0000, 8'b0100_0000, 4'd1, 4'd1, 1'b0, 5);
        run_word("bp2", 8'h81, 8'h81, 8'b1000_0000, 8'h00, 1'b0,
                 8'b1000_0000, 8'h00, 4'd1, 4'd0, 1'b1, 0);

        // Reset mid-SHIFT aborts the word.
        flag_me  = 1'b1;
        flag_mo  = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hFF;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b1;
        #1;
        chk("mid_rst.out_valid", out_valid, 1'b0);
        chk("mid_rst.in_ready", in_ready, 1'b1);
        chk("mid_rst.det_din", det_din, 1'b0);
        chk("mid_rst.masks", {me_mask, mo_mask}, 16'h0000);
        #9;
        rst_n   = 1'b0;
        flag_me = 1'b0;
        flag_mo = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            chk($sformatf("mid_rst.no_result[%0d]", k), out_valid, 1'b0);
        end
        chk("mid_rst.idle_after", in_ready, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_det_ctrl.md
Name: seq_det_ctrl

Overview:
- Controller that sequences the serial sequence-detector datapath (Mealy and Moore detectors sharing one `din`).
- Accepts parallel words on a valid/ready input, serializes them MSB-first onto `det_din`, and captures both detector flags bit-aligned, compensating for the Moore detector's one-cycle lag.
- Returns per-word hit masks, hit counts and a Mealy/Moore disagreement flag on a valid/ready output.
- Sits between the test/stream source and the `mealy`/`moore` instances.

Parameters:
- WIDTH, 8, bits per input word.
- CNT_W, 4, width of hit counters; must satisfy 2^CNT_W-1 >= WIDTH.
- IDLE_BIT, 1'b0, value driven on `det_din` outside SHIFT.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-high (asserted = 1); name kept as in codebase.
- in_valid  in  1  input word valid.
- in_ready  out  1  controller can accept a word.
- in_data  in  WIDTH  word to serialize; bit WIDTH-1 is sent first.
- det_din  out  1  serial bit to both detectors (registered).
- flag_me  in  1  Mealy detector flag; aligned with the current `det_din` bit.
- flag_mo  in  1  Moore detector flag; refers to the bit driven one cycle earlier.
- out_valid  out  1  result valid.
- out_ready  in  1  result consumer ready.
- me_mask  out  WIDTH  bit i set = Mealy hit on `in_data[i]`.
- mo_mask  out  WIDTH  bit i set = Moore hit attributed to `in_data[i]`.
- me_cnt  out  CNT_W  popcount of `me_mask`.
- mo_cnt  out  CNT_W  popcount of `mo_mask`.
- mismatch  out  1  `me_mask != mo_mask`.

Behaviour:
- States:
  - IDLE: `in_ready` = 1.
  - SHIFT: WIDTH cycles.
  - DRAIN: 1 cycle.
  - RESULT: `out_valid` = 1.
- `in_ready` is a combinational decode of state (IDLE only); `out_valid` is a decode of RESULT.
- Reset (async, rst_n=1): state=IDLE, `det_din`=IDLE_BIT, shift register, bit counter, masks and counts = 0, `mismatch`=0, `out_valid`=0. Reset mid-word aborts the word silently; no partial result is produced.
- IDLE: on edge with `in_valid` & `in_ready` (edge E0), load `in_data`, set `det_din`=`in_data[WIDTH-1]`, clear masks/counts, bit index=WIDTH-1, go to SHIFT.
- SHIFT, cycle carrying bit index i:
  - Sample `flag_me` into `me_mask[i]`.
  - Sample `flag_mo` into `mo_mask[i+1]` when i<WIDTH-1. The `flag_mo` value during the first SHIFT cycle is ignored (it belongs to the prior bit).
  - Drive the next bit; after bit 0, drive IDLE_BIT and go to DRAIN.
- DRAIN: sample `flag_mo` into `mo_mask[0]`; go to RESULT.
- Counts and `mismatch` are computed from the masks on the DRAIN→RESULT edge. Counts never exceed WIDTH, so no saturation is needed.
- Flags are ignored in IDLE and RESULT. `det_din`=IDLE_BIT there, so detector state sees IDLE_BIT gaps between words.
- Latency: `out_valid` rises on edge E0+WIDTH+1 (E9 at default).
- RESULT holds all outputs stable until `out_valid` & `out_ready`, then goes to IDLE. There is no same-cycle bypass to a new accept: `in_ready` rises the cycle after the handshake.
- Best-case throughput with `out_ready` tied high: one word per WIDTH+3 cycles.
- `in_valid` during SHIFT/DRAIN/RESULT is back-pressured; `in_data` is not sampled.

Decomposition:
- Shared package `seq_det_pkg`: state enum (IDLE, SHIFT, DRAIN, RESULT) and default WIDTH/CNT_W/IDLE_BIT constants.
- One sub-module, `det_hit_capture`: takes the bit index, sample enables and the two flags; owns both masks with the one-cycle Moore offset; produces popcounts and `mismatch`.
- The FSM, shift register and handshakes stay in `seq_det_ctrl`.

Test Plan:
- Reset: assert rst_n=1 for 10 time units mid-SHIFT → `out_valid`=0, `in_ready`=1, `det_din`=0, masks=0; no result emitted for the aborted word.
- Serialization: `in_data`=8'b1010_1011, flag stubs tied 0 → `det_din` sequence 1,0,1,0,1,0,1,1, then 0. `out_valid` at E9, `me_mask`=`mo_mask`=0, counts 0, `mismatch`=0.
- Alignment: stub pulses `flag_me` in the 5th SHIFT cycle and `flag_mo` in the 6th → `me_mask`=`mo_mask`=8'b0000_1000, `me_cnt`=`mo_cnt`=1, `mismatch`=0.
- Last-bit/DRAIN: stub `flag_me` in the 8th SHIFT cycle and `flag_mo` in DRAIN → both masks 8'b0000_0001. With the `flag_mo` pulse omitted → `mo_mask`=0, `mismatch`=1.
- Saturation of masks: `flag_me`=`flag_mo`=1 constantly → `me_mask`=`mo_mask`=8'hFF, counts=8, first-cycle `flag_mo` ignored.
- Back-pressure: hold `out_ready`=0 for 5 cycles with `in_valid`=1 → outputs stable, `in_ready`=0. Release → handshake, then `in_ready`=1 next cycle and the second word is accepted on the following edge.
